// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretcher
//  Description : Turns single-cycle event pulses into fixed-length LED flashes
//                separated by a dark gap; overlapping events are queued.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretcher #(
   parameter int ON_CYCLES  = 25000000,
   parameter int GAP_CYCLES = 12500000,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse,
   input  logic             clr_ovf,
   output logic             led,
   output logic             busy,
   output logic [CNT_W-1:0] pending,
   output logic             overflow
);

   localparam int               C_T_MAX    = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
   localparam int               C_TMR_W    = $clog2(C_T_MAX) + 1;
   localparam logic [C_TMR_W-1:0] C_ON_LAST  = C_TMR_W'(ON_CYCLES - 1);
   localparam logic [C_TMR_W-1:0] C_GAP_LAST = C_TMR_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]   C_PEND_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [C_TMR_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0]   pend_q,  pend_d;
   logic               ovf_q,   ovf_d;
   logic               led_q,   led_d;
   logic               busy_q,  busy_d;
   logic               w_inc;
   logic               w_dec;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 1'b1;
      w_inc   = 1'b0;
      w_dec   = 1'b0;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (pulse) begin
               state_d = S_ON;
            end
         end
         S_ON: begin
            w_inc = pulse;
            if (timer_q == C_ON_LAST) begin
               state_d = S_GAP;
               timer_d = '0;
            end
         end
         S_GAP: begin
            if (timer_q == C_GAP_LAST) begin
               timer_d = '0;
               if (pend_q != '0) begin
                  state_d = S_ON;
                  w_dec   = 1'b1;
                  w_inc   = pulse;
               end else if (pulse) begin
                  // Empty queue: the arriving pulse starts the next flash directly.
                  state_d = S_ON;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               w_inc = pulse;
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase
   end

   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (clr_ovf) begin
         ovf_d = 1'b0;
      end
      if (w_inc && w_dec) begin
         pend_d = pend_q;
      end else if (w_dec) begin
         pend_d = pend_q - 1'b1;
      end else if (w_inc) begin
         // A full queue drops the event; the set beats a same-cycle clear.
         if (pend_q == C_PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + 1'b1;
         end
      end
   end

   always_comb begin
      led_d  = (state_d == S_ON);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
      end
   end

   assign led      = led_q;
   assign busy     = busy_q;
   assign pending  = pend_q;
   assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_stretcher
//  Description : Scoreboard bench for pulse_stretcher (ON=4, GAP=2, CNT_W=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretcher;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic       pulse   = 1'b0;
   logic       clr_ovf = 1'b0;
   logic       led;
   logic       busy;
   logic [1:0] pending;
   logic       overflow;

   pulse_stretcher #(
      .ON_CYCLES (4),
      .GAP_CYCLES(2),
      .CNT_W     (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .pulse   (pulse),
      .clr_ovf (clr_ovf),
      .led     (led),
      .busy    (busy),
      .pending (pending),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Edge index since the last reset release; edge 1 is the first posedge.
   int edge_n;
   always @(posedge clk or negedge rst) begin
      if (!rst) edge_n <= 0;
      else      edge_n <= edge_n + 1;
   end

   // Observed vector: {led, busy, overflow, pending[1:0]}
   logic [4:0] obs;
   assign obs = {led, busy, overflow, pending};

   typedef struct {
      int         ed;
      logic [4:0] v;
   } chg_t;

   chg_t       exq[$];
   chg_t       got;
   logic [4:0] prev;
   int         checks   = 0;
   int         failures = 0;

   function automatic void push_exp(input int ed, input logic [4:0] v);
      chg_t c;
      c.ed = ed;
      c.v  = v;
      exq.push_back(c);
   endfunction

   // Monitor: every output change is an event, matched in order against the queue.
   always @(negedge clk) begin
      if (!rst) begin
         prev = obs;
      end else if (obs !== prev) begin
         checks++;
         if (exq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change edge=%0d got=%b want=none", edge_n, obs);
         end else begin
            got = exq.pop_front();
            if (got.ed != edge_n || got.v !== obs) begin
               failures++;
               $display("FAIL output_change got edge=%0d val=%b want edge=%0d val=%b",
                        edge_n, obs, got.ed, got.v);
            end
         end
         prev = obs;
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic run(input int len, input logic [63:0] pm, input logic [63:0] cm);
      for (int k = 1; k <= len; k++) begin
         pulse   = pm[k];
         clr_ovf = cm[k];
         @(posedge clk);
         #1;
      end
      pulse   = 1'b0;
      clr_ovf = 1'b0;
   endtask

   task automatic end_test(input string name);
      @(negedge clk);
      #1;
      checks++;
      if (exq.size() != 0) begin
         failures++;
         $display("FAIL %s missing_changes got=%0d want=0 (next edge=%0d val=%b)",
                  name, exq.size(), exq[0].ed, exq[0].v);
      end
      exq.delete();
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (obs !== 5'b00000) begin
         failures++;
         $display("FAIL %s got=%b want=00000", name, obs);
      end
   endtask

   logic [63:0] pm;
   logic [63:0] cm;

   initial begin
      do_reset();
      @(negedge clk);
      check_zero("reset_state");

      // Single pulse from IDLE
      pm = '0; cm = '0; pm[10] = 1'b1;
      push_exp(10, 5'b11000);
      push_exp(14, 5'b01000);
      push_exp(16, 5'b00000);
      run(20, pm, cm);
      end_test("single");

      // Two pulses, second one queued
      do_reset();
      pm = '0; cm = '0; pm[10] = 1'b1; pm[12] = 1'b1;
      push_exp(10, 5'b11000);
      push_exp(12, 5'b11001);
      push_exp(14, 5'b01001);
      push_exp(16, 5'b11000);
      push_exp(20, 5'b01000);
      push_exp(22, 5'b00000);
      run(26, pm, cm);
      end_test("queued");

      // Eight back-to-back pulses: saturation, overflow, replay, then clear
      do_reset();
      pm = '0; cm = '0;
      for (int k = 10; k <= 17; k++) pm[k] = 1'b1;
      pm[44] = 1'b1; cm[44] = 1'b1;
      push_exp(10, 5'b11000);
      push_exp(11, 5'b11001);
      push_exp(12, 5'b11010);
      push_exp(13, 5'b11011);
      push_exp(14, 5'b01111);
      push_exp(16, 5'b11111);
      push_exp(20, 5'b01111);
      push_exp(22, 5'b11110);
      push_exp(26, 5'b01110);
      push_exp(28, 5'b11101);
      push_exp(32, 5'b01101);
      push_exp(34, 5'b11100);
      push_exp(38, 5'b01100);
      push_exp(40, 5'b00100);
      push_exp(44, 5'b11000);
      push_exp(48, 5'b01000);
      push_exp(50, 5'b00000);
      run(54, pm, cm);
      end_test("saturate");

      // Pulse on the final gap edge with an empty queue is promoted
      do_reset();
      pm = '0; cm = '0; pm[10] = 1'b1; pm[16] = 1'b1;
      push_exp(10, 5'b11000);
      push_exp(14, 5'b01000);
      push_exp(16, 5'b11000);
      push_exp(20, 5'b01000);
      push_exp(22, 5'b00000);
      run(26, pm, cm);
      end_test("promote");

      // Pulse on the dequeue edge with pending=2 leaves pending unchanged
      do_reset();
      pm = '0; cm = '0; pm[10] = 1'b1; pm[11] = 1'b1; pm[12] = 1'b1; pm[16] = 1'b1;
      push_exp(10, 5'b11000);
      push_exp(11, 5'b11001);
      push_exp(12, 5'b11010);
      push_exp(14, 5'b01010);
      push_exp(16, 5'b11010);
      push_exp(20, 5'b01010);
      push_exp(22, 5'b11001);
      push_exp(26, 5'b01001);
      push_exp(28, 5'b11000);
      push_exp(32, 5'b01000);
      push_exp(34, 5'b00000);
      run(38, pm, cm);
      end_test("deq_cancel");

      // Asynchronous reset mid-flash with pending=2 and overflow set
      do_reset();
      pm = '0; cm = '0;
      for (int k = 10; k <= 14; k++) pm[k] = 1'b1;
      push_exp(10, 5'b11000);
      push_exp(11, 5'b11001);
      push_exp(12, 5'b11010);
      push_exp(13, 5'b11011);
      push_exp(14, 5'b01111);
      push_exp(16, 5'b11110);
      run(17, pm, cm);
      checks++;
      if (obs !== 5'b11110) begin
         failures++;
         $display("FAIL pre_reset got=%b want=11110", obs);
      end
      #1 rst = 1'b0;
      #1 check_zero("async_reset");
      end_test("pre_reset_events");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      pm = '0; cm = '0; pm[5] = 1'b1;
      push_exp(5, 5'b11000);
      push_exp(9, 5'b01000);
      push_exp(11, 5'b00000);
      run(14, pm, cm);
      end_test("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
